// File: rtl/fft_r22sdf_bfii_stage.sv
// R2^2SDF type-II butterfly stage. It sequences itself from an internal sample counter and uses a feedback delay line.
// Optional build macro FFT_BFII_SCALE_EN: round-half-up halving of the output (OW = DW).
module fft_r22sdf_bfii_stage #(
  parameter int DW            = 25,
  parameter int SHIFT_REG_LEN = 1,
  localparam int LOG2L = (SHIFT_REG_LEN > 1) ? $clog2(SHIFT_REG_LEN) : 0,
  localparam int CW    = LOG2L + 2,
`ifdef FFT_BFII_SCALE_EN
  localparam int OW    = DW
`else
  localparam int OW    = DW + 1
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic                 sync_i,
  input  logic                 inv_i,
  input  logic signed [DW-1:0] x_re_i,
  input  logic signed [DW-1:0] x_im_i,
  output logic                 valid_o,
  output logic                 sync_o,
  output logic signed [OW-1:0] z_re_o,
  output logic signed [OW-1:0] z_im_o
);

  // Handshake: valid-only, there is no back-pressure. A sample is accepted on every rising
  // edge where valid_i is high. On any other cycle, cnt, the delay line, z and sync_o keep their values.

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_eff;
  logic [CW-1:0]   cnt_nxt;
  logic            sel;
  logic            tsel;

  logic signed [DW:0] dl_re [SHIFT_REG_LEN];
  logic signed [DW:0] dl_im [SHIFT_REG_LEN];

  logic signed [DW:0] x_re_ext, x_im_ext;
  logic signed [DW:0] xsr_re, xsr_im;
  logic signed [DW:0] zf_re, zf_im;
  logic signed [DW:0] push_re, push_im;
  logic signed [OW-1:0] zo_re, zo_im;

  // A sync realigns the phase on the same sample that carries it.
  assign cnt_eff = sync_i ? '0 : cnt;
  assign cnt_nxt = cnt_eff + CW'(1);
  assign sel     = cnt_eff[LOG2L];
  assign tsel    = ~cnt_eff[LOG2L+1];

  assign x_re_ext = {x_re_i[DW-1], x_re_i};
  assign x_im_ext = {x_im_i[DW-1], x_im_i};
  assign xsr_re   = dl_re[SHIFT_REG_LEN-1];
  assign xsr_im   = dl_im[SHIFT_REG_LEN-1];

  always_comb begin
    zf_re   = xsr_re;
    zf_im   = xsr_im;
    push_re = x_re_ext;
    push_im = x_im_ext;
    if (sel) begin
      if (tsel) begin
        zf_re   = xsr_re + x_re_ext;
        zf_im   = xsr_im + x_im_ext;
        push_re = xsr_re - x_re_ext;
        push_im = xsr_im - x_im_ext;
      end else if (!inv_i) begin
        // Forward direction: x is rotated by -j.
        zf_re   = xsr_re + x_im_ext;
        zf_im   = xsr_im - x_re_ext;
        push_re = xsr_re - x_im_ext;
        push_im = xsr_im + x_re_ext;
      end else begin
        zf_re   = xsr_re - x_im_ext;
        zf_im   = xsr_im + x_re_ext;
        push_re = xsr_re + x_im_ext;
        push_im = xsr_im - x_re_ext;
      end
    end
  end

`ifdef FFT_BFII_SCALE_EN
  // Widen by one bit before adding the rounding constant, so the +1 cannot wrap.
  assign zo_re = OW'(($signed({zf_re[DW], zf_re}) + $signed((DW+2)'(1))) >>> 1);
  assign zo_im = OW'(($signed({zf_im[DW], zf_im}) + $signed((DW+2)'(1))) >>> 1);
`else
  assign zo_re = zf_re;
  assign zo_im = zf_im;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < SHIFT_REG_LEN; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else if (valid_i) begin
      cnt      <= cnt_nxt;
      dl_re[0] <= push_re;
      dl_im[0] <= push_im;
      for (int i = 1; i < SHIFT_REG_LEN; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      sync_o  <= 1'b0;
      z_re_o  <= '0;
      z_im_o  <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        sync_o <= sync_i;
        z_re_o <= zo_re;
        z_im_o <= zo_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_r22sdf_bfii_stage.sv
// Directed bench for fft_r22sdf_bfii_stage with DW=8 and L=1, using hand-computed vectors.
module tb_fft_r22sdf_bfii_stage;

  localparam int DW = 8;
  localparam int L  = 1;
`ifdef FFT_BFII_SCALE_EN
  localparam int OW = DW;
`else
  localparam int OW = DW + 1;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid_i = 1'b0;
  logic                 sync_i = 1'b0;
  logic                 inv_i = 1'b0;
  logic signed [DW-1:0] x_re_i = '0;
  logic signed [DW-1:0] x_im_i = '0;
  logic                 valid_o;
  logic                 sync_o;
  logic signed [OW-1:0] z_re_o;
  logic signed [OW-1:0] z_im_o;

  int total = 0;
  int bad   = 0;

  fft_r22sdf_bfii_stage #(.DW(DW), .SHIFT_REG_LEN(L)) dut (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .sync_i  (sync_i),
    .inv_i   (inv_i),
    .x_re_i  (x_re_i),
    .x_im_i  (x_im_i),
    .valid_o (valid_o),
    .sync_o  (sync_o),
    .z_re_o  (z_re_o),
    .z_im_o  (z_im_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected output for a full-width result, with optional round-half-up halving.
  function automatic int sc(input int v);
`ifdef FFT_BFII_SCALE_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_z(input string tag, input int er, input int ei);
    chk({tag, ".re"}, 32'(z_re_o), 32'(sc(er)));
    chk({tag, ".im"}, 32'(z_im_o), 32'(sc(ei)));
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    sync_i  = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
  endtask

  // Present one sample, let the next rising edge accept it, then sample 1 ns later.
  task automatic drive(input logic v, input logic s, input logic inv, input int re, input int im);
    valid_i = v;
    sync_i  = s;
    inv_i   = inv;
    x_re_i  = DW'(re);
    x_im_i  = DW'(im);
    @(posedge clk_i);
    #1;
  endtask

  int xr [5] = '{10, 3, 5, 0, 0};
  int xi [5] = '{0, 0, 0, 2, 0};
  int ef [5] = '{0, 13, 7, 7, 3};
  int ei [5] = '{0, 13, 7, 3, 7};
  int pulses;
  int hold_re, hold_im;

  initial begin
    // Reset state
    #2;
    chk("rst.valid_o", 32'(valid_o), 32'd0);
    chk("rst.sync_o", 32'(sync_o), 32'd0);
    chk("rst.z_re", 32'(z_re_o), 32'd0);
    chk("rst.z_im", 32'(z_im_o), 32'd0);
    do_reset();

    // Forward rotation
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k == 0, 1'b0, xr[k], xi[k]);
      chk_z($sformatf("fwd[%0d]", k), ef[k], 0);
      chk($sformatf("fwd[%0d].valid", k), 32'(valid_o), 32'd1);
      chk($sformatf("fwd[%0d].sync", k), 32'(sync_o), 32'(k == 0));
    end

    // Inverse rotation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k == 0, 1'b1, xr[k], xi[k]);
      chk_z($sformatf("inv[%0d]", k), ei[k], 0);
    end

    // Stall: three idle cycles carrying random data after every sample
    do_reset();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k == 0, 1'b0, xr[k], xi[k]);
      if (valid_o) pulses++;
      chk_z($sformatf("stall[%0d]", k), ef[k], 0);
      hold_re = int'(z_re_o);
      hold_im = int'(z_im_o);
      for (int g = 0; g < 3; g++) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        if (valid_o) pulses++;
        chk($sformatf("stall[%0d].gap%0d.re", k, g), 32'(z_re_o), 32'(hold_re));
        chk($sformatf("stall[%0d].gap%0d.im", k, g), 32'(z_im_o), 32'(hold_im));
      end
    end
    chk("stall.pulses", 32'(pulses), 32'd5);

    // Growth: the most negative inputs need the extra bit
    do_reset();
    drive(1'b1, 1'b1, 1'b0, -128, -128);
    chk_z("grow[0]", 0, 0);
    drive(1'b1, 1'b0, 1'b0, -128, -128);
    chk_z("grow[1]", -256, -256);
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    chk_z("grow[2]", 0, 0);

    // Mid-frame sync: the phase realigns and the delay line keeps its contents
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 10, 0);
    drive(1'b1, 1'b0, 1'b0, 3, 0);
    chk_z("msync[1]", 13, 0);
    drive(1'b1, 1'b1, 1'b0, 1, 0);
    chk_z("msync[2]", 7, 0);
    chk("msync[2].sync", 32'(sync_o), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 2, 0);
    chk_z("msync[3]", 3, 0);

    // Asynchronous reset mid-cycle after leaving cnt=3 and a nonzero delay line
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 10, 0);
    drive(1'b1, 1'b0, 1'b0, 3, 0);
    drive(1'b1, 1'b0, 1'b0, 5, 0);
    valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid_o", 32'(valid_o), 32'd0);
    chk("arst.sync_o", 32'(sync_o), 32'd0);
    chk("arst.z_re", 32'(z_re_o), 32'd0);
    chk("arst.z_im", 32'(z_im_o), 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    drive(1'b1, 1'b0, 1'b0, 10, 0);
    chk_z("arst.after[0]", 0, 0);
    chk("arst.after[0].valid", 32'(valid_o), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 3, 0);
    chk_z("arst.after[1]", 13, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_r22sdf_bfii_stage.md
Name: fft_r22sdf_bfii_stage

Overview:
Parametrised, self-sequencing R2²SDF type-II butterfly stage with a feedback delay line and a valid-qualified stall-able datapath.
- Generates its own sel/tsel phase from an internal sample counter, so the caller no longer supplies them.
- Carries one bit of growth internally and registers its output.
- Supports forward (-j) and inverse (+j) trivial rotation.
- Sits between a BFI stage and the twiddle multiplier of an R2²SDF pipeline.

Parameters:
DW, 25, input sample width per component (signed, two's complement).
SHIFT_REG_LEN, 1, feedback delay depth L; power of 2, >=1; LOG2L = clog2(L).
OW, derived: DW+1, or DW when FFT_BFII_SCALE_EN is defined; output width.

Ports:
clk_i  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  input sample valid; the stage advances only when high
sync_i  in  1  frame start; qualified by valid_i
inv_i  in  1  0 = forward (-j rotation), 1 = inverse (+j rotation); sampled with each valid sample
x_re_i  in  DW  input real part
x_im_i  in  DW  input imaginary part
valid_o  out  1  output valid
sync_o  out  1  sync_i delayed alongside data
z_re_o  out  OW  output real part
z_im_o  out  OW  output imaginary part

Behaviour:
- Reset (async, rst_n=0) clears the following to 0 immediately, regardless of clock:
  - all outputs;
  - counter cnt (LOG2L+2 bits);
  - all delay-line entries (DW+1 bits each, re and im).
- Accepted sample = valid_i high on a rising edge. On no other cycle do cnt, the delay line or data outputs change.
- Phase decode for each accepted sample:
  - sel = cnt[LOG2L], tsel = ~cnt[LOG2L+1]; here cnt is the effective count for this sample.
  - Effective count is 0 if sync_i=1 with the sample, else the current cnt.
  - After each accepted sample, cnt becomes effective count + 1, mod 4L (wrap-around).
- Input sign-extended to DW+1; xsr = oldest delay-line entry.
- sel=0: z = xsr; push x.
- sel=1, tsel=1: z = xsr + x; push xsr - x.
- sel=1, tsel=0, inv_i=0: z = (xsr_re + x_im, xsr_im - x_re); push (xsr_re - x_im, xsr_im + x_re).
- sel=1, tsel=0, inv_i=1: z = (xsr_re - x_im, xsr_im + x_re); push (xsr_re + x_im, xsr_im - x_re).
- Width: all arithmetic is DW+1 bits. Delay-line contents never exceed the DW+1 range, so no wrap is possible.
- Latency: z, valid_o and sync_o are registered 1 cycle after the accepted sample.
- valid_o = registered valid_i; z/sync_o hold their value when valid_o=0.
- The first L outputs after reset or first sync are flushed delay-line zeros. These are still flagged valid_o=1; downstream uses sync_o for alignment.
- sync_i mid-frame: cnt realigns on that sample. Delay-line contents are kept, not cleared.
- Reset mid-frame: the state is lost and the sequence restarts at cnt=0 on the next accepted sample.

Optional Feature:
FFT_BFII_SCALE_EN defined:
- Output = (DW+1 result + 1) >>> 1, i.e. round half up, arithmetic shift; OW=DW.
- The delay line remains DW+1, unscaled.
Undefined: output is the full DW+1 result, no rounding.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> all outputs and cnt read 0 before the next clk edge.
- DW=8, L=1, forward: valid each cycle, sync with x0, x=(10,0),(3,0),(5,0),(0,2),(0,0) -> z one cycle later = (0,0),(13,0),(7,0),(7,0),(3,0).
- Same stimulus with inv_i=1 -> (0,0),(13,0),(7,0),(3,0),(7,0).
- Stall: same stimulus as the forward case with valid_i low for 3 cycles between each sample -> identical z sequence; valid_o pulses exactly 5 times; z holds during gaps.
- Growth: DW=8, x0=(-128,-128), x1=(-128,-128) -> z=(-256,-256) on 9 bits, then the next output is (0,0).
- FFT_BFII_SCALE_EN: forward stimulus -> z for x1 = (7,0); growth case gives (-128,-128).
